// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU.
// - Opcode encodings (OP_ADD..OP_MUL); codes 9 and above are reserved.
// - Bit positions of the C/L/F/Z/N flags inside the flag register.
// - Controller FSM state encoding.
package alu_pkg;

    localparam int unsigned OP_ADD = 0;
    localparam int unsigned OP_SUB = 1;
    localparam int unsigned OP_CMP = 2;
    localparam int unsigned OP_AND = 3;
    localparam int unsigned OP_OR  = 4;
    localparam int unsigned OP_XOR = 5;
    localparam int unsigned OP_MOV = 6;
    localparam int unsigned OP_LSH = 7;
    localparam int unsigned OP_MUL = 8;

    localparam int unsigned FLAG_C    = 0;
    localparam int unsigned FLAG_L    = 1;
    localparam int unsigned FLAG_F    = 2;
    localparam int unsigned FLAG_Z    = 3;
    localparam int unsigned FLAG_N    = 4;
    localparam int unsigned NUM_FLAGS = 5;

    typedef enum logic [0:0] {
        StIdle,
        StMul
    } state_e;

endpackage

// File: rtl/alu_seq_if.sv
// Issue/result interface between the execute-stage controller and the ALU.
// - start/op/a/b : issue request from the controller
// - ready/done   : handshake back to the controller
// - result, C/L/F/Z/N : registered result and persistent flags
// The master modport is the controller side; the slave modport is the ALU side.
interface alu_seq_if #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned OPW   = 4
) ();

    logic             start;
    logic [OPW-1:0]   op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             ready;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             C;
    logic             L;
    logic             F;
    logic             Z;
    logic             N;

    modport master (
        output start, op, a, b,
        input  ready, done, result, C, L, F, Z, N
    );

    modport slave (
        input  start, op, a, b,
        output ready, done, result, C, L, F, Z, N
    );

endinterface

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier, one partial product per step.
// - clk, reset_n : clock and synchronous active-low reset
// - load_i       : capture a_i/b_i and clear the accumulator
// - step_i       : add one partial product and advance the counter
// - last_o       : the current step is the final (WIDTH-th) one
// - prod_o       : full 2*WIDTH product including the current step's partial product
module alu_mul_iter #(
    parameter int unsigned WIDTH = 16
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               load_i,
    input  logic               step_i,
    input  logic [WIDTH-1:0]   a_i,
    input  logic [WIDTH-1:0]   b_i,
    output logic               last_o,
    output logic [2*WIDTH-1:0] prod_o
);

    localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [CntW-1:0]    cnt_q, cnt_d;

    // Exposing the post-step sum lets the parent commit on the last step without an extra cycle.
    assign prod_o = acc_q + (mplier_q[0] ? mcand_q : '0);
    assign last_o = (cnt_q == CntW'(WIDTH - 1));

    always_comb begin
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        if (load_i) begin
            acc_d    = '0;
            mcand_d  = {{WIDTH{1'b0}}, a_i};
            mplier_d = b_i;
            cnt_d    = '0;
        end else if (step_i) begin
            acc_d    = prod_o;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + CntW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
        end else begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Registered execute-stage ALU with a persistent flag register.
// - clk, reset_n : clock and synchronous active-low reset (aborts an in-flight MUL)
// - bus (slave)  : start/op/a/b issue, ready/done handshake, result and C/L/F/Z/N flags
// Single-cycle ops commit on the accepting edge; MUL takes WIDTH further edges.
module alu_seq
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned OPW   = 4
) (
    input  logic     clk,
    input  logic     reset_n,
    alu_seq_if.slave bus
);

    localparam int unsigned Msb = WIDTH - 1;

    state_e               state_q, state_d;
    logic [WIDTH-1:0]     result_q, result_d;
    logic [NUM_FLAGS-1:0] flags_q, flags_d;
    logic                 done_q, done_d;

    logic                 mul_load, mul_step, mul_last;
    logic [2*WIDTH-1:0]   mul_prod;

    logic [WIDTH:0]       add_full, sub_full;
    logic                 add_ovf, sub_ovf;
    logic                 lsh_neg;
    logic [WIDTH-1:0]     lsh_mag, lsh_res;

    alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
        .clk    (clk),
        .reset_n(reset_n),
        .load_i (mul_load),
        .step_i (mul_step),
        .a_i    (bus.a),
        .b_i    (bus.b),
        .last_o (mul_last),
        .prod_o (mul_prod)
    );

    assign add_full = {1'b0, bus.a} + {1'b0, bus.b};
    assign sub_full = {1'b0, bus.a} - {1'b0, bus.b};
    assign add_ovf  = (bus.a[Msb] == bus.b[Msb]) && (add_full[Msb] != bus.a[Msb]);
    assign sub_ovf  = (bus.a[Msb] != bus.b[Msb]) && (sub_full[Msb] != bus.a[Msb]);

    // Shift amounts of WIDTH or more already yield zero, including the most negative b.
    assign lsh_neg  = bus.b[Msb];
    assign lsh_mag  = lsh_neg ? -bus.b : bus.b;
    assign lsh_res  = lsh_neg ? (bus.a >> lsh_mag) : (bus.a << lsh_mag);

    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        flags_d  = flags_q;
        done_d   = 1'b0;
        mul_load = 1'b0;
        mul_step = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    done_d = 1'b1;
                    case (bus.op)
                        OPW'(OP_ADD): begin
                            result_d        = add_full[WIDTH-1:0];
                            flags_d[FLAG_C] = add_full[WIDTH];
                            flags_d[FLAG_F] = add_ovf;
                        end
                        OPW'(OP_SUB): begin
                            result_d        = sub_full[WIDTH-1:0];
                            flags_d[FLAG_C] = sub_full[WIDTH];
                            flags_d[FLAG_F] = sub_ovf;
                        end
                        OPW'(OP_CMP): begin
                            flags_d[FLAG_Z] = (bus.a == bus.b);
                            flags_d[FLAG_L] = (bus.a < bus.b);
                            flags_d[FLAG_N] = ($signed(bus.a) < $signed(bus.b));
                        end
                        OPW'(OP_AND): result_d = bus.a & bus.b;
                        OPW'(OP_OR):  result_d = bus.a | bus.b;
                        OPW'(OP_XOR): result_d = bus.a ^ bus.b;
                        OPW'(OP_MOV): result_d = bus.b;
                        OPW'(OP_LSH): result_d = lsh_res;
                        OPW'(OP_MUL): begin
                            done_d   = 1'b0;
                            mul_load = 1'b1;
                            state_d  = StMul;
                        end
                        default: ; // reserved: done pulse only
                    endcase
                end
            end
            StMul: begin
                mul_step = 1'b1;
                if (mul_last) begin
                    result_d        = mul_prod[WIDTH-1:0];
                    flags_d[FLAG_F] = |mul_prod[2*WIDTH-1:WIDTH];
                    done_d          = 1'b1;
                    state_d         = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q  <= StIdle;
            result_q <= '0;
            flags_q  <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            flags_q  <= flags_d;
            done_q   <= done_d;
        end
    end

    assign bus.ready  = (state_q == StIdle);
    assign bus.done   = done_q;
    assign bus.result = result_q;
    assign bus.C      = flags_q[FLAG_C];
    assign bus.L      = flags_q[FLAG_L];
    assign bus.F      = flags_q[FLAG_F];
    assign bus.Z      = flags_q[FLAG_Z];
    assign bus.N      = flags_q[FLAG_N];

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: a 16-bit and an 8-bit instance share clock and reset. An arithmetic
// reference model per instance is compared against every output on every falling edge, and
// directed vectors carry hand-computed literal expectations. Flags read as {N,Z,F,L,C}.
module tb_alu_seq;

    localparam int unsigned OPW = 4;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    alu_seq_if #(.WIDTH(16), .OPW(OPW)) if16 ();
    alu_seq_if #(.WIDTH(8),  .OPW(OPW)) if8 ();

    alu_seq #(.WIDTH(16), .OPW(OPW)) u_dut16 (.clk(clk), .reset_n(reset_n), .bus(if16));
    alu_seq #(.WIDTH(8),  .OPW(OPW)) u_dut8  (.clk(clk), .reset_n(reset_n), .bus(if8));

    typedef struct {
        bit     busy;
        int     cnt;
        longint ma;
        longint mb;
        longint r;
        bit     c, l, f, z, n;
        bit     done;
    } model_t;

    model_t m16, m8;
    int     n_cmp = 0;
    int     n_bad = 0;
    bit     checking = 1'b0;

    // Architectural effect of one op on result/flags, in plain integer arithmetic.
    function automatic void apply_op(input int w, input int op, input longint a, input longint b,
                                     inout model_t m);
        longint mask, msb, full, sa, sb, s;
        mask = (64'sd1 <<< w) - 1;
        msb  = 64'sd1 <<< (w - 1);
        case (op)
            0: begin
                full = a + b;
                m.r  = full & mask;
                m.c  = (full >>> w) != 0;
                m.f  = ((a ^ m.r) & (b ^ m.r) & msb) != 0;
            end
            1: begin
                m.r = (a - b) & mask;
                m.c = a < b;
                m.f = ((a ^ b) & (a ^ m.r) & msb) != 0;
            end
            2: begin
                sa  = ((a & msb) != 0) ? a - (64'sd1 <<< w) : a;
                sb  = ((b & msb) != 0) ? b - (64'sd1 <<< w) : b;
                m.z = a == b;
                m.l = a < b;
                m.n = sa < sb;
            end
            3: m.r = a & b;
            4: m.r = a | b;
            5: m.r = a ^ b;
            6: m.r = b;
            7: begin
                s = ((b & msb) != 0) ? b - (64'sd1 <<< w) : b;
                if (s >= 0) m.r = (s >= w) ? 0 : ((a <<< s) & mask);
                else        m.r = (-s >= w) ? 0 : (a >>> (-s));
            end
            8: begin
                full = a * b;
                m.r  = full & mask;
                m.f  = (full >>> w) != 0;
            end
            default: ;
        endcase
    endfunction

    task automatic model_tick(input int w, input logic rst_n, input logic st, input int op,
                              input longint a, input longint b, inout model_t m);
        if (!rst_n) begin
            m.busy = 0; m.cnt = 0; m.r = 0; m.done = 0;
            m.c = 0; m.l = 0; m.f = 0; m.z = 0; m.n = 0;
        end else begin
            m.done = 0;
            if (m.busy) begin
                m.cnt--;
                if (m.cnt == 0) begin
                    apply_op(w, 8, m.ma, m.mb, m);
                    m.done = 1;
                    m.busy = 0;
                end
            end else if (st) begin
                if (op == 8) begin
                    m.busy = 1; m.cnt = w; m.ma = a; m.mb = b;
                end else begin
                    apply_op(w, op, a, b, m);
                    m.done = 1;
                end
            end
        end
    endtask

    always @(posedge clk) begin
        model_tick(16, reset_n, if16.start, int'(if16.op), longint'(if16.a), longint'(if16.b),
                   m16);
        model_tick(8, reset_n, if8.start, int'(if8.op), longint'(if8.a), longint'(if8.b), m8);
    end

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cmp_dut(input string tag, input model_t m, input logic rdy, input logic dn,
                           input longint res, input logic [4:0] fl);
        check({tag, " ready"},  longint'(rdy), m.busy ? 64'd0 : 64'd1);
        check({tag, " done"},   longint'(dn),  longint'(m.done));
        check({tag, " result"}, res,           m.r);
        check({tag, " flags"},  longint'(fl),  longint'({m.n, m.z, m.f, m.l, m.c}));
    endtask

    function automatic logic [4:0] flg(input bit w8);
        return w8 ? {if8.N, if8.Z, if8.F, if8.L, if8.C}
                  : {if16.N, if16.Z, if16.F, if16.L, if16.C};
    endfunction

    function automatic longint res(input bit w8);
        return w8 ? longint'(if8.result) : longint'(if16.result);
    endfunction

    function automatic logic dn(input bit w8);
        return w8 ? if8.done : if16.done;
    endfunction

    function automatic logic rdy(input bit w8);
        return w8 ? if8.ready : if16.ready;
    endfunction

    always @(negedge clk) begin
        if (checking) begin
            cmp_dut("d16", m16, if16.ready, if16.done, longint'(if16.result), flg(0));
            cmp_dut("d8",  m8,  if8.ready,  if8.done,  longint'(if8.result),  flg(1));
        end
    end

    task automatic drive(input bit w8, input logic st, input int op, input longint a,
                         input longint b);
        if (w8) begin
            if8.start = st; if8.op = OPW'(op); if8.a = 8'(a); if8.b = 8'(b);
        end else begin
            if16.start = st; if16.op = OPW'(op); if16.a = 16'(a); if16.b = 16'(b);
        end
    endtask

    // Leaves the bench at the falling edge right after the accepting edge.
    task automatic do_op(input bit w8, input int op, input longint a, input longint b);
        @(negedge clk);
        drive(w8, 1'b1, op, a, b);
        @(negedge clk);
        drive(w8, 1'b0, 0, 0, 0);
    endtask

    task automatic do_mul(input bit w8, input longint a, input longint b, input int exp_lat,
                          input bit poke);
        int lat;
        do_op(w8, 8, a, b);
        check("mul busy", longint'(rdy(w8)), 0);
        lat = 0;
        while (!dn(w8) && lat < 40) begin
            if (poke && lat == 3) drive(w8, 1'b1, 0, 1, 1);
            if (poke && lat == 4) drive(w8, 1'b0, 0, 0, 0);
            @(negedge clk);
            lat++;
        end
        check("mul latency", lat, exp_lat);
    endtask

    initial begin
        int n_done;
        drive(0, 1'b0, 0, 0, 0);
        drive(1, 1'b0, 0, 0, 0);
        reset_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checking = 1'b1;
        check("rst result", res(0), 0);
        check("rst flags", longint'(flg(0)), 0);
        check("rst ready", longint'(rdy(0)), 1);
        check("rst done", longint'(dn(0)), 0);
        reset_n = 1'b1;

        do_op(0, 0, 'h3, 'h1);
        check("add3+1 result", res(0), 'h4);
        check("add3+1 done", longint'(dn(0)), 1);
        check("add3+1 flags", longint'(flg(0)), 'b00000);
        @(negedge clk);
        check("add3+1 done one cycle", longint'(dn(0)), 0);

        do_op(0, 1, 'h1, 'h3);
        check("sub1-3 result", res(0), 'hFFFE);
        check("sub1-3 flags", longint'(flg(0)), 'b00001);
        do_op(0, 2, 'h3, 'h3);
        check("cmp3,3 flags", longint'(flg(0)), 'b01001);
        do_op(0, 2, 'h2, 'h3);
        check("cmp2,3 flags", longint'(flg(0)), 'b10011);
        do_op(0, 2, 'hFFFF, 'h1);
        check("cmpFFFF,1 flags", longint'(flg(0)), 'b10001);
        do_op(0, 3, 'h2, 'h3);
        check("and result", res(0), 'h2);
        check("and flags", longint'(flg(0)), 'b10001);

        do_op(0, 0, 'h7FFF, 'h1);
        check("add7FFF result", res(0), 'h8000);
        check("add7FFF flags", longint'(flg(0)), 'b10100);
        do_op(0, 0, 'hFFFF, 'h1);
        check("addFFFF result", res(0), 'h0);
        check("addFFFF flags", longint'(flg(0)), 'b10001);

        do_mul(0, 'h00FF, 'h0101, 16, 1'b1);
        check("mulFF result", res(0), 'hFFFF);
        check("mulFF flags", longint'(flg(0)), 'b10001);
        do_mul(0, 'h1000, 'h0010, 16, 1'b0);
        check("mul1000 result", res(0), 'h0);
        check("mul1000 flags", longint'(flg(0)), 'b10101);

        do_op(0, 7, 'h0081, 'h0002);
        check("lsh+2", res(0), 'h0204);
        do_op(0, 7, 'h0081, 'hFFFE);
        check("lsh-2", res(0), 'h0020);
        do_op(0, 7, 'h0081, 'h0010);
        check("lsh16", res(0), 'h0);
        check("lsh flags", longint'(flg(0)), 'b10101);

        @(negedge clk);
        drive(0, 1'b1, 5, 'h00F0, 'h0FF0);
        @(negedge clk);
        drive(0, 1'b1, 4, 'h1200, 'h0034);
        check("b2b xor", res(0), 'h0F00);
        @(negedge clk);
        drive(0, 1'b1, 6, 'h0, 'hBEEF);
        check("b2b or", res(0), 'h1234);
        @(negedge clk);
        drive(0, 1'b0, 0, 0, 0);
        check("b2b mov", res(0), 'hBEEF);
        check("b2b mov done", longint'(dn(0)), 1);
        @(negedge clk);
        check("b2b done drop", longint'(dn(0)), 0);

        do_op(0, 9, 'h1, 'h1);
        check("rsvd done", longint'(dn(0)), 1);
        check("rsvd result", res(0), 'hBEEF);
        check("rsvd flags", longint'(flg(0)), 'b10101);

        do_op(0, 8, 'h3, 'h5);
        repeat (4) @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        check("abort ready", longint'(rdy(0)), 1);
        check("abort done", longint'(dn(0)), 0);
        check("abort result", res(0), 0);
        n_done = 0;
        repeat (20) begin
            @(negedge clk);
            if (dn(0)) n_done++;
        end
        check("abort no done", n_done, 0);

        do_op(1, 0, 'h7F, 'h01);
        check("w8 add7F result", res(1), 'h80);
        check("w8 add7F flags", longint'(flg(1)), 'b00100);
        do_op(1, 0, 'hFF, 'h01);
        check("w8 addFF result", res(1), 'h0);
        check("w8 addFF flags", longint'(flg(1)), 'b00001);
        do_mul(1, 'h0F, 'h11, 8, 1'b1);
        check("w8 mul0F result", res(1), 'hFF);
        check("w8 mul0F flags", longint'(flg(1)), 'b00001);
        do_mul(1, 'h10, 'h10, 8, 1'b0);
        check("w8 mul10 result", res(1), 'h0);
        check("w8 mul10 flags", longint'(flg(1)), 'b00101);

        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
